// File: rtl/beat_sequencer_if.sv
// Control and status bundle between the key/switch front end and the beat sequencer.
// The master drives transport controls and tempo; the slave returns beat index and status.
interface beat_sequencer_if;
  logic       play;
  logic       pause;
  logic       stop;
  logic       loop_en;
  logic [1:0] tempo_sel;
  logic [7:0] beats;
  logic       beat_strobe;
  logic       note_gate;
  logic       playing;
  logic       song_done;

  modport master (
    output play, pause, stop, loop_en, tempo_sel,
    input  beats, beat_strobe, note_gate, playing, song_done
  );

  modport slave (
    input  play, pause, stop, loop_en, tempo_sel,
    output beats, beat_strobe, note_gate, playing, song_done
  );
endinterface

// File: rtl/beat_sequencer.sv
// Beat index generator for the song players: tempo-scaled tick counter, transport FSM
// (idle/play/pause/done) and a note gate that closes for the last GAP_TICKS of every beat.
module beat_sequencer #(
  parameter int BEAT_TICKS = 6250000,
  parameter int GAP_TICKS  = 625000,
  parameter int SONG_LEN   = 68,
  parameter int CNT_W      = 32
) (
  input logic             CLOCK_50,
  input logic             reset,
  beat_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_DONE} state_t;
  typedef enum logic [1:0] {CMD_NONE, CMD_PLAY, CMD_PAUSE, CMD_STOP} cmd_t;

  localparam logic [7:0]       LAST_BEAT = 8'(SONG_LEN - 1);
  localparam logic [CNT_W-1:0] BASE_LEN  = CNT_W'(BEAT_TICKS);
  localparam logic [CNT_W-1:0] GAP_LEN   = CNT_W'(GAP_TICKS);

  state_t           state, state_nx;
  logic [CNT_W-1:0] tick, tick_nx;
  logic [CNT_W-1:0] beat_len, beat_len_nx;
  logic [7:0]       beats, beats_nx;
  logic             strobe, strobe_nx;
  logic             gate, gate_nx;
  logic             play_q, pause_q, stop_q, armed;
  cmd_t             cmd;
  logic [CNT_W-1:0] tempo_len;

  // armed stays low for the first cycle after reset so a key held through release
  // is captured into its edge register without being seen as a press.
  always_comb begin
    cmd = CMD_NONE;
    if (armed) begin
      if (bus.stop && !stop_q)        cmd = CMD_STOP;
      else if (bus.pause && !pause_q) cmd = CMD_PAUSE;
      else if (bus.play && !play_q)   cmd = CMD_PLAY;
    end
  end

  always_comb begin
    unique case (bus.tempo_sel)
      2'b01:   tempo_len = BASE_LEN >> 1;
      2'b10:   tempo_len = BASE_LEN << 1;
      default: tempo_len = BASE_LEN;
    endcase
  end

  // NOTE: every output of this block is assigned a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    tick_nx     = tick;
    beats_nx    = beats;
    beat_len_nx = beat_len;
    strobe_nx   = 1'b0;

    unique case (state)
      S_IDLE: begin
        tick_nx  = '0;
        beats_nx = '0;
        if (cmd == CMD_PLAY) begin
          state_nx    = S_PLAY;
          beat_len_nx = tempo_len;
          strobe_nx   = 1'b1;
        end
      end

      S_PLAY: begin
        if (cmd == CMD_STOP) begin
          state_nx = S_IDLE;
          tick_nx  = '0;
          beats_nx = '0;
        end else if (cmd == CMD_PAUSE) begin
          state_nx = S_PAUSE;
        end else if (tick == beat_len - 1'b1) begin
          tick_nx     = '0;
          beat_len_nx = tempo_len;
          if (beats == LAST_BEAT) begin
            // Finishing holds the last beat, so there is no index change to strobe.
            if (bus.loop_en) begin
              beats_nx  = '0;
              strobe_nx = 1'b1;
            end else begin
              state_nx = S_DONE;
            end
          end else begin
            beats_nx  = beats + 8'd1;
            strobe_nx = 1'b1;
          end
        end else begin
          tick_nx = tick + 1'b1;
        end
      end

      S_PAUSE: begin
        if (cmd == CMD_STOP) begin
          state_nx = S_IDLE;
          tick_nx  = '0;
          beats_nx = '0;
        end else if (cmd == CMD_PAUSE || cmd == CMD_PLAY) begin
          state_nx = S_PLAY;
        end
      end

      S_DONE: begin
        if (cmd == CMD_STOP) begin
          state_nx = S_IDLE;
          tick_nx  = '0;
          beats_nx = '0;
        end else if (cmd == CMD_PLAY) begin
          state_nx    = S_PLAY;
          tick_nx     = '0;
          beats_nx    = '0;
          beat_len_nx = tempo_len;
          strobe_nx   = 1'b1;
        end
      end

      default: state_nx = S_IDLE;
    endcase

    // Gate is computed from next-state values so the registered gate lines up with tick.
    gate_nx = (state_nx == S_PLAY) && (tick_nx < beat_len_nx - GAP_LEN);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      tick     <= '0;
      beat_len <= BASE_LEN;
      beats    <= '0;
      strobe   <= 1'b0;
      gate     <= 1'b0;
      play_q   <= 1'b0;
      pause_q  <= 1'b0;
      stop_q   <= 1'b0;
      armed    <= 1'b0;
    end else begin
      state    <= state_nx;
      tick     <= tick_nx;
      beat_len <= beat_len_nx;
      beats    <= beats_nx;
      strobe   <= strobe_nx;
      gate     <= gate_nx;
      play_q   <= bus.play;
      pause_q  <= bus.pause;
      stop_q   <= bus.stop;
      armed    <= 1'b1;
    end
  end

  assign bus.beats       = beats;
  assign bus.beat_strobe = strobe;
  assign bus.note_gate   = gate;
  assign bus.playing     = (state == S_PLAY);
  assign bus.song_done   = (state == S_DONE);

endmodule
